fpu_tile_seq: RTL and testbench
===============================

FPU_TILE_SEQ -- requirements
Module: fpu_tile_seq

Interface
REQ-001 SHALL have parameter CSR_IN_WIDTH, default 16: command CSR width, minimum 16.
REQ-002 SHALL have parameter CSR_OUT_WIDTH, default 16: status CSR width, minimum 16.
REQ-003 SHALL have parameter REG_WIDTH, default 32: operand/result width (IEEE-754 single at 32).
REQ-004 SHALL have parameter CORE_LAT, default 2: cycles from add_sub_main operand presentation to valid R, range 1..15.
REQ-005 SHALL have port clk  input  1  clock; all state on its rising edge.
REQ-006 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port csr_in  input  CSR_IN_WIDTH  command: [15] start, [5] accumulate, [4] op (0 add, 1 sub).
REQ-008 SHALL have port csr_in_re  output  1  one-cycle pulse: command consumed.
REQ-009 SHALL have port data_reg_a  input  REG_WIDTH  operand A.
REQ-010 SHALL have port data_reg_b  input  REG_WIDTH  operand B.
REQ-011 SHALL have port csr_out  output  CSR_OUT_WIDTH  status: [0] busy, [1] done, [2] overrun, [15:8] completed-op count, others 0.
REQ-012 SHALL have port csr_out_we  output  1  one-cycle pulse: csr_out holds a new completion status.
REQ-013 SHALL have port data_reg_c  output  REG_WIDTH  registered result.

Function
REQ-014 SHALL instantiate add_sub_main once: en, a, b, operation_select from captured registers; R sampled only by this block.
REQ-015 SHALL implement FSM IDLE, CAPTURE, EXEC, DONE; encoding free.
REQ-016 Start SHALL be edge-armed: accepted in IDLE when csr_in[15]=1 and csr_in[15] was 0 in any earlier cycle since the last acceptance or reset.
REQ-017 On acceptance (cycle T) SHALL pulse csr_in_re at T+1 and enter CAPTURE.
REQ-018 CAPTURE SHALL register data_reg_a, data_reg_b, csr_in[4], csr_in[5] in one cycle, then enter EXEC.
REQ-019 EXEC SHALL hold add_sub_main en=1 for exactly CORE_LAT cycles, counted by a down-counter loaded with CORE_LAT-1, then enter DONE.
REQ-020 DONE (cycle T+2+CORE_LAT) SHALL load R into data_reg_c, set done=1, increment count, pulse csr_out_we, return to IDLE next cycle.
REQ-021 busy SHALL be 1 in CAPTURE, EXEC, DONE; 0 in IDLE.
REQ-022 done SHALL be sticky, cleared on next acceptance.
REQ-023 Rising edge of csr_in[15] while busy SHALL be ignored and SHALL set sticky overrun; overrun cleared on next acceptance.
REQ-024 A start rising edge in the same cycle the FSM returns to IDLE SHALL be treated as while busy (ignored, overrun set).
REQ-025 Count SHALL wrap 255 -> 0 with no flag.
REQ-026 Operand inputs SHALL be don't-care outside the CAPTURE sampling cycle; data_reg_c SHALL change only in DONE.
REQ-027 add_sub_main en SHALL be 0 outside EXEC.

Reset
REQ-028 arst_n low SHALL asynchronously force IDLE, data_reg_c=0, csr_out=0, csr_in_re=0, csr_out_we=0, count=0, start arm cleared.
REQ-029 Reset mid-operation SHALL abandon the operation with no csr_out_we pulse and no data_reg_c update.
REQ-030 After reset release, csr_in[15] SHALL be seen 0 at least once before a start is accepted.

Configuration
REQ-031 With macro FPU_TILE_ACCUM_EN defined, captured accumulate=1 SHALL substitute current data_reg_c for operand A; data_reg_a ignored.
REQ-032 Without FPU_TILE_ACCUM_EN, csr_in[5] SHALL be ignored and no substitution logic SHALL exist.

Verification
REQ-033 A=0x3F800000, B=0x40000000, op=0, start edge -> csr_in_re at T+1; data_reg_c=0x40400000 and csr_out_we at T+2+CORE_LAT; csr_out=0x0102.
REQ-034 Same operands, op=1 -> data_reg_c=0xBF800000; count field increments to 2.
REQ-035 Second start edge during EXEC -> no csr_in_re, result unaffected, csr_out bit2=1 at completion; next accepted start clears it.
REQ-036 arst_n low during EXEC -> all outputs 0 asynchronously, no csr_out_we; csr_in[15] held 1 through release -> no acceptance until it drops and rises.
REQ-037 FPU_TILE_ACCUM_EN defined, data_reg_c=0x40400000, B=0x3F800000, accumulate=1, op=0 -> data_reg_c=0x40800000.
REQ-038 256 back-to-back operations -> count field wraps to 0x00, done=1.

Source files
------------

// File: rtl/fpu_tile_seq.sv
// fpu_tile_seq: single-operation floating-point add/sub tile sequencer.
// A rising edge on the command start bit launches one add or subtract on the
// captured operands through add_sub_main. The result is posted to data_reg_c
// together with a one-cycle status-write pulse.
// Build option: define FPU_TILE_ACCUM_EN to let a captured accumulate bit
// replace operand A with the current data_reg_c. Without it, csr_in[5] has no
// effect.

module add_sub_main #(
    parameter int REG_WIDTH = 32,
    parameter int CORE_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 en,
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] b,
    input  logic                 operation_select,
    output logic [REG_WIDTH-1:0] R
);
    localparam int EXP_W = (REG_WIDTH == 64) ? 11 : ((REG_WIDTH == 16) ? 5 : 8);
    localparam int MAN_W = REG_WIDTH - 1 - EXP_W;
    // hidden bit + fraction + guard/round/sticky
    localparam int WW    = MAN_W + 4;
    localparam int EMAX  = (1 << EXP_W) - 1;

    logic [REG_WIDTH-1:0] sum_res;

    // IEEE add/sub, round-to-nearest-even, denormals kept, quiet-NaN on invalid
    always_comb begin
        logic             sa, sb, sbig, a_nan, b_nan, a_inf, b_inf, swap, inc;
        logic [EXP_W-1:0] ea, eb;
        logic [MAN_W-1:0] fa, fb;
        logic [WW-1:0]    ma, mb, mbig, msml, sh, lost, norm;
        logic [WW:0]      acc;
        logic [MAN_W+1:0] rnd;
        int               xa, xb, xbig, xsml, d, lz, s, ex, ef;

        sa    = a[REG_WIDTH-1];
        sb    = b[REG_WIDTH-1] ^ operation_select;
        ea    = a[REG_WIDTH-2:MAN_W];
        eb    = b[REG_WIDTH-2:MAN_W];
        fa    = a[MAN_W-1:0];
        fb    = b[MAN_W-1:0];
        a_nan = (&ea) && (|fa);
        b_nan = (&eb) && (|fb);
        a_inf = (&ea) && !(|fa);
        b_inf = (&eb) && !(|fb);
        ma    = {|ea, fa, 3'b000};
        mb    = {|eb, fb, 3'b000};
        // denormals share the scale of exponent field 1
        xa    = (ea == '0) ? 1 : int'(ea);
        xb    = (eb == '0) ? 1 : int'(eb);

        swap  = {eb, fb} > {ea, fa};
        sbig  = swap ? sb : sa;
        mbig  = swap ? mb : ma;
        msml  = swap ? ma : mb;
        xbig  = swap ? xb : xa;
        xsml  = swap ? xa : xb;

        d     = xbig - xsml;
        sh    = msml >> d;
        lost  = msml & ~({WW{1'b1}} << d);
        sh[0] = sh[0] | (|lost);

        if (sa == sb) acc = {1'b0, mbig} + {1'b0, sh};
        else          acc = {1'b0, mbig} - {1'b0, sh};

        lz = WW;
        for (int i = 0; i < WW; i++) begin
            if (acc[i]) lz = WW - 1 - i;
        end

        s = 0;
        if (acc[WW]) begin
            norm = {acc[WW:2], acc[1] | acc[0]};
            ex   = xbig + 1;
        end else begin
            // stop normalising at the denormal boundary
            s    = (lz < xbig - 1) ? lz : xbig - 1;
            norm = acc[WW-1:0] << s;
            ex   = xbig - s;
        end

        inc = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd = {1'b0, norm[WW-1:3]} + {{(MAN_W+1){1'b0}}, inc};

        if (rnd[MAN_W+1])  ef = ex + 1;
        else if (rnd[MAN_W]) ef = ex;
        else               ef = 0;

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            sum_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (a_inf)
            sum_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (b_inf)
            sum_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (acc == '0)
            sum_res = {sa & sb, {(REG_WIDTH-1){1'b0}}};
        else if (ef >= EMAX)
            sum_res = {sbig, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            sum_res = {sbig, EXP_W'(ef), rnd[MAN_W-1:0]};
    end

    generate
        if (CORE_LAT == 1) begin : g_comb
            logic unused_core;
            assign unused_core = clk ^ arst_n ^ en;
            assign R = sum_res;
        end else begin : g_pipe
            logic [REG_WIDTH-1:0] pipe_q [CORE_LAT-1];
            // result pipeline advances only while the sequencer enables the core
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    for (int i = 0; i < CORE_LAT - 1; i++) pipe_q[i] <= '0;
                end else if (en) begin
                    pipe_q[0] <= sum_res;
                    for (int i = 1; i < CORE_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign R = pipe_q[CORE_LAT-2];
        end
    endgenerate
endmodule

// state   | meaning
// IDLE    | waiting for an armed start edge
// CAPTURE | registering operands, op and accumulate bits
// EXEC    | core enabled, latency down-counter running
// DONE    | result posted, status-write pulse high
module fpu_tile_seq #(
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16,
    parameter int REG_WIDTH     = 32,
    parameter int CORE_LAT      = 2
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [CSR_IN_WIDTH-1:0]  csr_in,
    output logic                     csr_in_re,
    input  logic [REG_WIDTH-1:0]     data_reg_a,
    input  logic [REG_WIDTH-1:0]     data_reg_b,
    output logic [CSR_OUT_WIDTH-1:0] csr_out,
    output logic                     csr_out_we,
    output logic [REG_WIDTH-1:0]     data_reg_c
);
    typedef enum logic [1:0] {IDLE, CAPTURE, EXEC, DONE} state_t;

    state_t               state_q;
    logic [3:0]           lat_q;
    logic [REG_WIDTH-1:0] a_q, b_q, res_q;
    logic                 op_q;
    logic                 armed_q, start_prev_q;
    logic                 busy_q, done_q, overrun_q, re_q, we_q;
    logic [7:0]           count_q;
    logic                 start, start_rise, accept, core_en;
    logic [REG_WIDTH-1:0] core_a, core_r;
    logic                 unused_csr;

    assign start      = csr_in[15];
    assign start_rise = start & ~start_prev_q;
    assign accept     = (state_q == IDLE) & start & armed_q;
    assign core_en    = (state_q == EXEC);
    assign unused_csr = ^csr_in;

`ifdef FPU_TILE_ACCUM_EN
    logic acc_q;
    assign core_a = acc_q ? res_q : a_q;
`else
    assign core_a = a_q;
`endif

    add_sub_main #(
        .REG_WIDTH (REG_WIDTH),
        .CORE_LAT  (CORE_LAT)
    ) u_core (
        .clk              (clk),
        .arst_n           (arst_n),
        .en               (core_en),
        .a                (core_a),
        .b                (b_q),
        .operation_select (op_q),
        .R                (core_r)
    );

    // sequencer: start arming, capture, latency count, result and status posting
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            op_q         <= 1'b0;
`ifdef FPU_TILE_ACCUM_EN
            acc_q        <= 1'b0;
`endif
            armed_q      <= 1'b0;
            start_prev_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            count_q      <= '0;
        end else begin
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            start_prev_q <= start;
            if (!start) armed_q <= 1'b1;
            // an edge seen while busy (DONE included) is dropped and disarms the start
            if ((state_q != IDLE) && start_rise) begin
                overrun_q <= 1'b1;
                armed_q   <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= CAPTURE;
                        busy_q    <= 1'b1;
                        re_q      <= 1'b1;
                        done_q    <= 1'b0;
                        overrun_q <= 1'b0;
                        armed_q   <= 1'b0;
                    end
                end
                CAPTURE: begin
                    a_q     <= data_reg_a;
                    b_q     <= data_reg_b;
                    op_q    <= csr_in[4];
`ifdef FPU_TILE_ACCUM_EN
                    acc_q   <= csr_in[5];
`endif
                    lat_q   <= 4'(CORE_LAT - 1);
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (lat_q == '0) begin
                        state_q <= DONE;
                        res_q   <= core_r;
                        done_q  <= 1'b1;
                        we_q    <= 1'b1;
                        count_q <= count_q + 8'd1;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // status word assembly from registered flags; unused bits read as zero
    always_comb begin
        csr_out       = '0;
        csr_out[0]    = busy_q;
        csr_out[1]    = done_q;
        csr_out[2]    = overrun_q;
        csr_out[15:8] = count_q;
    end

    assign csr_in_re  = re_q;
    assign csr_out_we = we_q;
    assign data_reg_c = res_q;
endmodule

// File: tb/tb_fpu_tile_seq.sv
// Directed bench for fpu_tile_seq: vector table of add/sub cases plus
// hand-written overrun, reset, accumulate and count-wrap sequences.
module tb_fpu_tile_seq;
    localparam int CL = 2;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [15:0] csr_in = '0;
    logic        csr_in_re;
    logic [31:0] da = '0;
    logic [31:0] db = '0;
    logic [15:0] csr_out;
    logic        csr_out_we;
    logic [31:0] data_reg_c;

    fpu_tile_seq #(
        .CSR_IN_WIDTH  (16),
        .CSR_OUT_WIDTH (16),
        .REG_WIDTH     (32),
        .CORE_LAT      (CL)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .csr_in     (csr_in),
        .csr_in_re  (csr_in_re),
        .data_reg_a (da),
        .data_reg_b (db),
        .csr_out    (csr_out),
        .csr_out_we (csr_out_we),
        .data_reg_c (data_reg_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
    } vec_t;

    vec_t        vecs [14];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_cnt = '0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic st, input logic acc, input logic op);
        csr_in     = '0;
        csr_in[15] = st;
        csr_in[5]  = acc;
        csr_in[4]  = op;
    endtask

    task automatic run_op(input string nm, input logic [31:0] va, input logic [31:0] vb,
                          input logic op, input logic acc, input logic [31:0] exp_r);
        int lat;
        cmd(1'b0, acc, op);
        step();
        da = va;
        db = vb;
        cmd(1'b1, acc, op);
        step();
        check({nm, " re"}, 32'(csr_in_re), 32'd1);
        check({nm, " status@accept"}, 32'(csr_out[2:0]), 32'h1);
        cmd(1'b0, acc, op);
        step();
        da = 32'hDEADBEEF;
        db = 32'h12345678;
        lat = 2;
        while (csr_out_we !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        exp_cnt++;
        check({nm, " latency"}, 32'(lat), 32'(CL + 2));
        check({nm, " result"}, data_reg_c, exp_r);
        check({nm, " status@done"}, 32'(csr_out), {16'h0, exp_cnt, 8'h03});
        step();
        check({nm, " we pulse"}, 32'(csr_out_we), 32'd0);
        check({nm, " status@idle"}, 32'(csr_out), {16'h0, exp_cnt, 8'h02});
        check({nm, " result hold"}, data_reg_c, exp_r);
    endtask

    initial begin
        int lat;
        int seen_re;
        int n_to;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
        vecs[1]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000};
        vecs[2]  = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000};
        vecs[3]  = '{32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000};
        vecs[4]  = '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000};
        vecs[5]  = '{32'hC0000000, 32'h3F000000, 1'b0, 32'hBFC00000};
        vecs[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000};
        vecs[7]  = '{32'h41200000, 32'h3DCCCCCD, 1'b0, 32'h4121999A};
        vecs[8]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
        vecs[9]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002};
        vecs[10] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
        vecs[11] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002};
        vecs[12] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
        vecs[13] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000};

        cmd(1'b0, 1'b0, 1'b0);
        #12;
        check("reset csr_out", 32'(csr_out), 32'h0);
        check("reset data_reg_c", data_reg_c, 32'h0);
        check("reset re/we", 32'({csr_in_re, csr_out_we}), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].r);
        end

        // overrun: second start edge while executing
        cmd(1'b0, 1'b0, 1'b0);
        step();
        da = 32'h3F800000;
        db = 32'h40000000;
        cmd(1'b1, 1'b0, 1'b0);
        step();
        check("ovr re", 32'(csr_in_re), 32'd1);
        cmd(1'b0, 1'b0, 1'b0);
        step();
        cmd(1'b1, 1'b0, 1'b0);
        da = '0;
        db = '0;
        seen_re = 0;
        lat = 2;
        while (csr_out_we !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (csr_in_re === 1'b1) seen_re++;
        end
        exp_cnt++;
        check("ovr latency", 32'(lat), 32'(CL + 2));
        check("ovr result", data_reg_c, 32'h40400000);
        check("ovr status@done", 32'(csr_out), {16'h0, exp_cnt, 8'h07});
        for (int k = 0; k < 5; k++) begin
            step();
            if (csr_in_re === 1'b1) seen_re++;
        end
        check("ovr no accept", 32'(seen_re), 32'd0);
        check("ovr sticky idle", 32'(csr_out), {16'h0, exp_cnt, 8'h06});
        run_op("after_ovr", 32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h40800000);

        // accumulate build option
        run_op("acc_seed", 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000);
`ifdef FPU_TILE_ACCUM_EN
        run_op("accum_on", 32'h7F800000, 32'h3F800000, 1'b0, 1'b1, 32'h40800000);
`else
        run_op("accum_off", 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h40000000);
`endif

        // reset during EXEC with start held high through release
        cmd(1'b0, 1'b0, 1'b0);
        step();
        da = 32'h40A00000;
        db = 32'h40A00000;
        cmd(1'b1, 1'b0, 1'b0);
        step();
        check("rst re", 32'(csr_in_re), 32'd1);
        step();
        #2;
        arst_n = 1'b0;
        #1;
        check("rst async csr_out", 32'(csr_out), 32'h0);
        check("rst async data", data_reg_c, 32'h0);
        check("rst async re/we", 32'({csr_in_re, csr_out_we}), 32'h0);
        exp_cnt = '0;
        seen_re = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (csr_out_we === 1'b1) seen_re++;
        end
        @(negedge clk);
        arst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (csr_in_re === 1'b1 || csr_out_we === 1'b1) seen_re++;
        end
        check("rst held start no accept", 32'(seen_re), 32'd0);
        check("rst held status", 32'(csr_out), 32'h0);
        check("rst held data", data_reg_c, 32'h0);
        run_op("post_rst", 32'h40A00000, 32'h40A00000, 1'b0, 1'b0, 32'h41200000);

        // start edge in the DONE cycle is treated as while busy
        cmd(1'b0, 1'b0, 1'b0);
        step();
        da = 32'h3F800000;
        db = 32'h3F800000;
        cmd(1'b1, 1'b0, 1'b0);
        step();
        cmd(1'b0, 1'b0, 1'b0);
        lat = 1;
        while (csr_out_we !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        exp_cnt++;
        cmd(1'b1, 1'b0, 1'b0);
        step();
        seen_re = 0;
        for (int k = 0; k < 3; k++) begin
            if (csr_in_re === 1'b1) seen_re++;
            step();
        end
        check("done-edge no accept", 32'(seen_re), 32'd0);
        check("done-edge overrun", 32'(csr_out), {16'h0, exp_cnt, 8'h06});
        check("done-edge result", data_reg_c, 32'h40000000);

        // count wrap over 256 back-to-back operations after a fresh reset
        arst_n = 1'b0;
        step();
        @(negedge clk);
        arst_n = 1'b1;
        exp_cnt = '0;
        cmd(1'b0, 1'b0, 1'b0);
        step();
        n_to = 0;
        for (int k = 0; k < 256; k++) begin
            cmd(1'b1, 1'b0, 1'b0);
            step();
            cmd(1'b0, 1'b0, 1'b0);
            lat = 1;
            while (csr_out_we !== 1'b1 && lat < 40) begin
                step();
                lat++;
            end
            if (lat >= 40) n_to++;
            exp_cnt++;
            if (k == 254) check("wrap count 255", 32'(csr_out[15:8]), 32'hFF);
            step();
        end
        check("wrap timeouts", 32'(n_to), 32'd0);
        check("wrap status", 32'(csr_out), 32'h0002);
        check("wrap result", data_reg_c, 32'h40000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
